// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Bundles every non-clock/reset signal of the ID/EX pipeline register.
//   i_*  : decode-side inputs (valid, control word, operands, instruction fields,
//          downstream hold, branch/jump flush)
//   o_*  : execute-side outputs (registered instruction, resolved destination,
//          decode stall, statistics counters, FSM state for observation)
// Modports:
//   master : the side that drives decode inputs and observes EX outputs
//   slave  : the ID/EX stage itself
// Handshake: o_stall=1 means the instruction presented on i_* this cycle is
// not consumed and decode must present it again; i_hold=1 freezes the stage.
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
    parameter int CTRL_W = 21,
    parameter int DATA_W = 32
);
    logic              i_valid;
    logic [CTRL_W-1:0] i_ctrl;
    logic [DATA_W-1:0] i_pc4;
    logic [DATA_W-1:0] i_rs_data;
    logic [DATA_W-1:0] i_rt_data;
    logic [DATA_W-1:0] i_imm;
    logic [4:0]        i_rs;
    logic [4:0]        i_rt;
    logic [4:0]        i_rd;
    logic [4:0]        i_sa;
    logic              i_hold;
    logic              i_flush;

    logic              o_stall;
    logic              o_valid;
    logic [CTRL_W-1:0] o_ctrl;
    logic [DATA_W-1:0] o_pc4;
    logic [DATA_W-1:0] o_rs_data;
    logic [DATA_W-1:0] o_rt_data;
    logic [DATA_W-1:0] o_imm;
    logic [4:0]        o_rs;
    logic [4:0]        o_rt;
    logic [4:0]        o_sa;
    logic [4:0]        o_dst;
    logic [15:0]       o_bubble_cnt;
    logic [15:0]       o_hold_cnt;
    logic              o_state_dbg;   // 1 = BUBBLE, 0 = RUN

    modport master (
        output i_valid, i_ctrl, i_pc4, i_rs_data, i_rt_data, i_imm,
               i_rs, i_rt, i_rd, i_sa, i_hold, i_flush,
        input  o_stall, o_valid, o_ctrl, o_pc4, o_rs_data, o_rt_data, o_imm,
               o_rs, o_rt, o_sa, o_dst, o_bubble_cnt, o_hold_cnt, o_state_dbg
    );

    modport slave (
        input  i_valid, i_ctrl, i_pc4, i_rs_data, i_rt_data, i_imm,
               i_rs, i_rt, i_rd, i_sa, i_hold, i_flush,
        output o_stall, o_valid, o_ctrl, o_pc4, o_rs_data, o_rt_data, o_imm,
               o_rs, o_rt, o_sa, o_dst, o_bubble_cnt, o_hold_cnt, o_state_dbg
    );
endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register. Captures the decoded control word and operands,
// resolves the write-back register, detects load-use hazards against the
// instruction in EX, stalls decode and inserts a single bubble.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset
//   bus    : id_ex_stage_if.slave (decode inputs, EX outputs, stall, stats)
// Optional feature: define ID_EX_STATS_EN to enable the 16-bit saturating
// bubble/hold counters; otherwise o_bubble_cnt/o_hold_cnt are tied to 0.
// Control word layout (MSB..LSB): ALU_src_a[20:19] ALU_src_b[18]
// ALU_dst[17:16] ALU_opcode[15:12] AGU_src_addr[11] AGU_dst[10]
// AGU_opcode[9:7] jump[6] branch[5] reg_wr_en[4] mem_wr_en[3] wb_src[2]
// extend_sign[1:0]
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int CTRL_W = 21,
    parameter int DATA_W = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    id_ex_stage_if.slave  bus
);
    localparam int ALU_DST_HI = 17;
    localparam int ALU_DST_LO = 16;
    localparam int REG_WR_BIT = 4;
    localparam int WB_SRC_BIT = 2;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [4:0]        rs_q, rs_d;
    logic [4:0]        rt_q, rt_d;
    logic [4:0]        sa_q, sa_d;
    logic [4:0]        dst_q, dst_d;

    logic              hazard;
    logic [4:0]        dst_sel;

    // A load (register write sourced from memory) in EX whose destination is
    // read by the instruction in decode cannot be forwarded in time.
    assign hazard = valid_q && ctrl_q[REG_WR_BIT] && !ctrl_q[WB_SRC_BIT] &&
                    (dst_q != 5'd0) && bus.i_valid &&
                    ((dst_q == bus.i_rs) || (dst_q == bus.i_rt));

    assign bus.o_stall = (hazard && !bus.i_flush) || bus.i_hold;

    always_comb begin
        dst_sel = bus.i_rt;
        unique case (bus.i_ctrl[ALU_DST_HI:ALU_DST_LO])
            2'b00: dst_sel = bus.i_rt;
            2'b01: dst_sel = bus.i_rd;
            2'b11: dst_sel = 5'd31;
            2'b10: dst_sel = 5'd0;
            default: dst_sel = bus.i_rt;
        endcase
    end

    // Next-state: flush > hold > hazard bubble > load.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        pc4_d     = pc4_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        sa_d      = sa_q;
        dst_d     = dst_q;
        if (bus.i_flush || (!bus.i_hold && hazard)) begin
            valid_d   = 1'b0;
            ctrl_d    = '0;
            pc4_d     = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            rs_d      = '0;
            rt_d      = '0;
            sa_d      = '0;
            dst_d     = '0;
            state_d   = bus.i_flush ? ST_RUN : ST_BUBBLE;
        end else if (!bus.i_hold) begin
            valid_d   = bus.i_valid;
            ctrl_d    = bus.i_valid ? bus.i_ctrl : '0;
            pc4_d     = bus.i_pc4;
            rs_data_d = bus.i_rs_data;
            rt_data_d = bus.i_rt_data;
            imm_d     = bus.i_imm;
            rs_d      = bus.i_rs;
            rt_d      = bus.i_rt;
            sa_d      = bus.i_sa;
            dst_d     = dst_sel;
            state_d   = ST_RUN;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_RUN;
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            pc4_q     <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            sa_q      <= '0;
            dst_q     <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            pc4_q     <= pc4_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            sa_q      <= sa_d;
            dst_q     <= dst_d;
        end
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_ctrl      = ctrl_q;
    assign bus.o_pc4       = pc4_q;
    assign bus.o_rs_data   = rs_data_q;
    assign bus.o_rt_data   = rt_data_q;
    assign bus.o_imm       = imm_q;
    assign bus.o_rs        = rs_q;
    assign bus.o_rt        = rt_q;
    assign bus.o_sa        = sa_q;
    assign bus.o_dst       = dst_q;
    assign bus.o_state_dbg = (state_q == ST_BUBBLE);

`ifdef ID_EX_STATS_EN
    logic [15:0] bubble_cnt_q;
    logic [15:0] hold_cnt_q;
    logic        bubble_ins;

    // Only a bubble actually written into EX counts; flush and hold mask it.
    assign bubble_ins = hazard && !bus.i_flush && !bus.i_hold;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bubble_cnt_q <= '0;
            hold_cnt_q   <= '0;
        end else begin
            if (bubble_ins && (bubble_cnt_q != 16'hFFFF))
                bubble_cnt_q <= bubble_cnt_q + 16'd1;
            if (bus.i_hold && (hold_cnt_q != 16'hFFFF))
                hold_cnt_q <= hold_cnt_q + 16'd1;
        end
    end

    assign bus.o_bubble_cnt = bubble_cnt_q;
    assign bus.o_hold_cnt   = hold_cnt_q;
`else
    assign bus.o_bubble_cnt = 16'd0;
    assign bus.o_hold_cnt   = 16'd0;
`endif

endmodule
